video_frame_checker: RTL and testbench
======================================

Name: video_frame_checker

Overview:
- Synthesisable in-line monitor that taps the video pipeline output (active/vsync/pixel bus).
- Per frame it computes a CRC-32 over all active pixels, measures line lengths and line count against the expected geometry, and reports results once per frame.
- Generalises frame capture from a simulation-only file writer to any channel count and width, with on-chip error detection usable in both the bench and the FPGA.

Parameters:
- WIDTH, 640, expected active pixels per line
- HEIGHT, 480, expected active lines per frame
- CW, 8, colour component width
- NCH, 3, colour channel count; NCH*CW must be in 8..64
- FCW, 16, frame counter width
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  video clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  video clock enable; all state advances only when high
- en  in  1  enable checker
- vid_active  in  1  pixel valid (not blanked)
- vid_vsync  in  1  vertical sync
- vid_dat  in  NCH*CW  pixel; channel 0 in the MSBs
- frame_done  out  1  one-clk pulse when a frame closes
- frame_crc  out  32  CRC of the last closed frame
- frame_cnt  out  FCW  closed frames since enable; wraps
- err_line_len  out  1  last frame had a line whose length was not WIDTH
- err_line_cnt  out  1  last frame had a line count that was not HEIGHT
- busy  out  1  inside a frame (state ACTIVE)

Behaviour:
- Reset: all outputs 0; frame_crc = 0; FSM in IDLE.
- Clock and reset: one clock, synchronous active-high reset.
- Gating: with clk_en low, nothing changes, except that a frame_done pulse still drops after one clk.
- Vsync edge: vid_vsync is registered (vs_d). A vsync edge is the cycle where clk_en=1, vid_vsync==VS_POL and vs_d!=VS_POL.
- FSM IDLE: en=1 -> SYNC.
- FSM SYNC: wait for a vsync edge -> ACTIVE, then clear the accumulators. The partial frame seen before the first edge is ignored.
- FSM ACTIVE:
  - Each clk_en cycle with vid_active=1 feeds vid_dat to the CRC and increments the pixel-in-line counter, which saturates at 2^16-1.
  - A vid_active falling edge closes the line: line count +1 (saturating), and the sticky len_err is set if pixel count != WIDTH.
  - On a vsync edge the frame closes, registered in that clk edge:
    - frame_crc <= final CRC
    - err_line_len <= len_err
    - err_line_cnt <= (lines != HEIGHT)
    - frame_cnt + 1
    - frame_done = 1 for the next clk cycle
    - accumulators reinitialised; state stays ACTIVE.
- Simultaneous events:
  - If vid_active=1 on a closing vsync edge, the open line is closed into the old frame first.
  - That cycle's pixel starts the new frame's first line and CRC.
- en deassert (any state, clk_en=1): -> IDLE and abort. No frame_done. Result outputs keep their last values. frame_cnt is cleared on the next IDLE->SYNC transition.
- Reset mid-frame: immediate return to reset values; no pulse.
- CRC: CRC-32/BZIP2.
  - Polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - NCH*CW bits per pixel, processed MSB first in one cycle (unrolled).
- Latency: frame results are visible one clk after the closing vsync edge, coincident with frame_done.

Decomposition:
- Shared package video_pkg holds:
  - CRC32_POLY, CRC32_INIT, CRC32_XOROUT
  - FSM state enum (IDLE, SYNC, ACTIVE)
  - line counter width constant LCW=16
- Sub-module video_crc32 (params DW): ports clk, rst, clk_en, clr, en, dat[DW], crc[32] (post-XOR view). Holds the CRC register and an unrolled bitwise step loop.

Test Plan:
- CRC known answer: NCH=1, CW=8, WIDTH=9, HEIGHT=1. Vsync edge, then one line "123456789" (0x31..0x39), then vsync edge -> frame_done pulse, frame_crc=0xFC891918, both errors 0, frame_cnt=1.
- Default geometry: 640x480, pixel = {y,y,y}. Run two full frames -> frame_cnt=2, identical frame_crc both frames, errors 0.
- Short line: WIDTH=4, HEIGHT=2 with lines of 4 and 3 pixels -> err_line_len=1, err_line_cnt=0. The next good frame clears it to 0.
- Line count: 3 lines of 4 pixels for HEIGHT=2 -> err_line_cnt=1, err_line_len=0.
- Control and gating:
  - clk_en toggled 1/0 every cycle with duplicated stimulus -> results identical to the ungated run.
  - en dropped mid-frame -> no frame_done; busy=0 next cycle; frame_crc unchanged.
- Reset and edge cases:
  - rst asserted mid-frame -> all outputs 0 next clk.
  - vid_active high on the closing vsync edge -> the old line is counted in the old frame and the pixel goes to the new frame.
  - FCW=2 over 5 frames -> frame_cnt wraps 3->0->1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, FSM state type and helpers for the video frame checker.
package video_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  localparam int unsigned LCW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LCW-1:0] sat_inc(input logic [LCW-1:0] v);
    return (&v) ? v : v + LCW'(1);
  endfunction

endpackage

// File: rtl/video_crc32.sv
// CRC-32/BZIP2 accumulator: DW bits per cycle, MSB first, unrolled.
module video_crc32
  import video_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] dat,
  output logic [31:0]   crc
);

  logic [31:0] r_crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] v;
    v = c;
    for (int i = DW - 1; i >= 0; i--) begin
      v = {v[30:0], 1'b0} ^ (((v[31] ^ d[i]) == 1'b1) ? CRC32_POLY : 32'h0);
    end
    return v;
  endfunction

  // clr with en restarts the CRC and folds in this cycle's word in one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (clk_en) begin
      if (clr) begin
        r_crc <= en ? crc_step(CRC32_INIT, dat) : CRC32_INIT;
      end else if (en) begin
        r_crc <= crc_step(r_crc, dat);
      end
    end
  end

  assign crc = r_crc ^ CRC32_XOROUT;

endmodule

// File: rtl/video_frame_checker.sv
// In-line video monitor: per-frame CRC-32 plus line length / line count checks.
module video_frame_checker
  import video_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CW     = 8,
  parameter int unsigned NCH    = 3,
  parameter int unsigned FCW    = 16,
  parameter int unsigned VS_POL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              en,
  input  logic              vid_active,
  input  logic              vid_vsync,
  input  logic [NCH*CW-1:0] vid_dat,
  output logic              frame_done,
  output logic [31:0]       frame_crc,
  output logic [FCW-1:0]    frame_cnt,
  output logic              err_line_len,
  output logic              err_line_cnt,
  output logic              busy
);

  localparam int unsigned DW     = NCH * CW;
  localparam logic        VS_LVL = 1'(VS_POL);

  state_t         r_state;
  logic           r_vs_d;
  logic           r_act_d;
  logic [LCW-1:0] r_pix_cnt;
  logic [LCW-1:0] r_line_cnt;
  logic           r_len_err;
  logic           r_frame_done;
  logic [31:0]    r_frame_crc;
  logic [FCW-1:0] r_frame_cnt;
  logic           r_err_line_len;
  logic           r_err_line_cnt;

  logic           w_vs_edge;
  logic           w_frame_start;
  logic           w_crc_en;
  logic [31:0]    w_crc;
  logic           w_len_fin;
  logic [LCW-1:0] w_lines_fin;

  assign w_vs_edge     = clk_en && (vid_vsync == VS_LVL) && (r_vs_d != VS_LVL);
  assign w_frame_start = en && w_vs_edge && (r_state != IDLE);
  assign w_crc_en      = en && vid_active && ((r_state == ACTIVE) || w_frame_start);

  // A line still open at the closing vsync belongs to the frame being closed.
  assign w_len_fin   = r_len_err || (r_act_d && (r_pix_cnt != LCW'(WIDTH)));
  assign w_lines_fin = r_act_d ? sat_inc(r_line_cnt) : r_line_cnt;

  video_crc32 #(.DW(DW)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (w_frame_start),
    .en     (w_crc_en),
    .dat    (vid_dat),
    .crc    (w_crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_vs_d         <= 1'b0;
      r_act_d        <= 1'b0;
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      r_len_err      <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_crc    <= '0;
      r_frame_cnt    <= '0;
      r_err_line_len <= 1'b0;
      r_err_line_cnt <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (clk_en) begin
        r_vs_d  <= vid_vsync;
        r_act_d <= vid_active;
        if (!en) begin
          r_state <= IDLE;
        end else begin
          case (r_state)
            IDLE: begin
              r_state     <= SYNC;
              r_frame_cnt <= '0;
            end
            SYNC: begin
              if (w_vs_edge) begin
                r_state    <= ACTIVE;
                r_pix_cnt  <= vid_active ? LCW'(1) : '0;
                r_line_cnt <= '0;
                r_len_err  <= 1'b0;
              end
            end
            ACTIVE: begin
              if (w_vs_edge) begin
                r_frame_crc    <= w_crc;
                r_err_line_len <= w_len_fin;
                r_err_line_cnt <= (w_lines_fin != LCW'(HEIGHT));
                r_frame_cnt    <= r_frame_cnt + FCW'(1);
                r_frame_done   <= 1'b1;
                r_pix_cnt      <= vid_active ? LCW'(1) : '0;
                r_line_cnt     <= '0;
                r_len_err      <= 1'b0;
              end else if (vid_active) begin
                r_pix_cnt <= sat_inc(r_pix_cnt);
              end else begin
                if (r_act_d) begin
                  r_line_cnt <= sat_inc(r_line_cnt);
                  if (r_pix_cnt != LCW'(WIDTH)) begin
                    r_len_err <= 1'b1;
                  end
                end
                r_pix_cnt <= '0;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign frame_done   = r_frame_done;
  assign frame_crc    = r_frame_crc;
  assign frame_cnt    = r_frame_cnt;
  assign err_line_len = r_err_line_len;
  assign err_line_cnt = r_err_line_cnt;
  assign busy         = (r_state == ACTIVE);

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed bench: three checker instances on a shared video bus, one enabled per test.
module tb_video_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        vid_active;
  logic        vid_vsync;
  logic [23:0] vid_dat;
  logic        en_a, en_b, en_c;

  logic        done_a, done_b, done_c;
  logic [31:0] crc_a, crc_b, crc_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic        len_a, len_b, len_c;
  logic        lcnt_a, lcnt_b, lcnt_c;
  logic        busy_a, busy_b, busy_c;

  int          total = 0;
  int          bad   = 0;
  bit          gate  = 1'b0;
  int          mbits = 8;
  logic [31:0] mcrc  = 32'hFFFF_FFFF;
  logic [31:0] xcrc;
  logic        dsnap_a, dsnap_b, dsnap_c;
  logic        cd_a, cd_b, cd_c;

  always #5 clk = ~clk;

  // Known-answer geometry: one line of nine 8-bit pixels.
  video_frame_checker #(.WIDTH(9), .HEIGHT(1), .CW(8), .NCH(1), .FCW(16), .VS_POL(1)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .en(en_a), .vid_active(vid_active),
    .vid_vsync(vid_vsync), .vid_dat(vid_dat[7:0]), .frame_done(done_a), .frame_crc(crc_a),
    .frame_cnt(cnt_a), .err_line_len(len_a), .err_line_cnt(lcnt_a), .busy(busy_a));

  video_frame_checker #(.WIDTH(16), .HEIGHT(8), .CW(8), .NCH(3), .FCW(16), .VS_POL(1)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .en(en_b), .vid_active(vid_active),
    .vid_vsync(vid_vsync), .vid_dat(vid_dat), .frame_done(done_b), .frame_crc(crc_b),
    .frame_cnt(cnt_b), .err_line_len(len_b), .err_line_cnt(lcnt_b), .busy(busy_b));

  video_frame_checker #(.WIDTH(4), .HEIGHT(2), .CW(8), .NCH(1), .FCW(2), .VS_POL(1)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .en(en_c), .vid_active(vid_active),
    .vid_vsync(vid_vsync), .vid_dat(vid_dat[7:0]), .frame_done(done_c), .frame_crc(crc_c),
    .frame_cnt(cnt_c), .err_line_len(len_c), .err_line_cnt(lcnt_c), .busy(busy_c));

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] d,
                                            input int nb);
    logic [31:0] v;
    bit          fb;
    v = c;
    for (int i = nb - 1; i >= 0; i--) begin
      fb = v[31] ^ d[i];
      v  = v << 1;
      if (fb) v = v ^ 32'h04C1_1DB7;
    end
    return v;
  endfunction

  function automatic logic [23:0] pix(input int v);
    logic [7:0] b;
    b = 8'(v);
    return (mbits == 24) ? {b, b, b} : {16'h0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stimulus cycle; in gated mode the same inputs are held over a clk_en=0 cycle.
  task automatic cyc(input logic act, input logic vs, input logic [23:0] d);
    vid_active = act;
    vid_vsync  = vs;
    vid_dat    = d;
    clk_en     = 1'b1;
    tick();
    dsnap_a = done_a;
    dsnap_b = done_b;
    dsnap_c = done_c;
    if (gate) begin
      clk_en = 1'b0;
      tick();
      clk_en = 1'b1;
    end
  endtask

  task automatic send_line(input int n, input int base);
    logic [23:0] d;
    for (int x = 0; x < n; x++) begin
      d    = pix(base + x);
      mcrc = crc_model(mcrc, d, mbits);
      cyc(1'b1, 1'b0, d);
    end
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  task automatic vs_close();
    cyc(1'b0, 1'b1, 24'h0);
    cd_a = dsnap_a;
    cd_b = dsnap_b;
    cd_c = dsnap_c;
    xcrc = ~mcrc;
    mcrc = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    logic [23:0] p;
    rst = 1'b1; clk_en = 1'b1; vid_active = 1'b0; vid_vsync = 1'b0; vid_dat = '0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (3) tick();
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_crc", 64'(crc_a), 64'(0));
    chk("rst_cnt", 64'(cnt_a), 64'(0));
    chk("rst_errs", 64'({len_a, lcnt_a}), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    rst = 1'b0;
    tick();

    // CRC known answer on "123456789"
    en_a = 1'b1;
    cyc(1'b0, 1'b0, 24'h0);
    chk("sync_not_busy", 64'(busy_a), 64'(0));
    cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    chk("active_busy", 64'(busy_a), 64'(1));
    mbits = 8; mcrc = 32'hFFFF_FFFF;
    send_line(9, 8'h31);
    vs_close();
    chk("kat_done", 64'(cd_a), 64'(1));
    chk("kat_crc", 64'(crc_a), 64'(32'hFC89_1918));
    chk("kat_len", 64'(len_a), 64'(0));
    chk("kat_lcnt", 64'(lcnt_a), 64'(0));
    chk("kat_cnt", 64'(cnt_a), 64'(1));
    chk("kat_done_drop", 64'(done_a), 64'(0));

    // Same frame with clk_en toggling every cycle
    gate = 1'b1;
    send_line(9, 8'h31);
    vs_close();
    gate = 1'b0;
    chk("gate_done", 64'(cd_a), 64'(1));
    chk("gate_crc", 64'(crc_a), 64'(32'hFC89_1918));
    chk("gate_errs", 64'({len_a, lcnt_a}), 64'(0));
    chk("gate_cnt", 64'(cnt_a), 64'(2));

    // en dropped mid-frame
    for (int x = 0; x < 4; x++) cyc(1'b1, 1'b0, 24'(8'h50 + x));
    en_a = 1'b0;
    cyc(1'b1, 1'b0, 24'h55);
    chk("abort_busy", 64'(busy_a), 64'(0));
    cyc(1'b0, 1'b1, 24'h0);
    chk("abort_no_done", 64'(dsnap_a), 64'(0));
    cyc(1'b0, 1'b0, 24'h0);
    chk("abort_crc_kept", 64'(crc_a), 64'(32'hFC89_1918));
    chk("abort_cnt_kept", 64'(cnt_a), 64'(2));
    en_a = 1'b1;
    cyc(1'b0, 1'b0, 24'h0);
    chk("reenable_cnt_clr", 64'(cnt_a), 64'(0));
    en_a = 1'b0;
    cyc(1'b0, 1'b0, 24'h0);

    // 3-channel geometry, two identical frames of pixel {y,y,y}
    en_b = 1'b1;
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    mbits = 24; mcrc = 32'hFFFF_FFFF;
    for (int f = 1; f <= 2; f++) begin
      for (int y = 0; y < 8; y++) send_line(16, y * 16);
      vs_close();
      chk("rgb_done", 64'(cd_b), 64'(1));
      chk("rgb_crc", 64'(crc_b), 64'(xcrc));
      chk("rgb_errs", 64'({len_b, lcnt_b}), 64'(0));
      chk("rgb_cnt", 64'(cnt_b), 64'(f));
    end
    en_b = 1'b0;
    cyc(1'b0, 1'b0, 24'h0);

    // Small geometry 4x2 with a 2-bit frame counter
    en_c = 1'b1;
    mbits = 8; mcrc = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    send_line(4, 8'h10);
    send_line(3, 8'h20);
    vs_close();
    chk("short_done", 64'(cd_c), 64'(1));
    chk("short_crc", 64'(crc_c), 64'(xcrc));
    chk("short_len", 64'(len_c), 64'(1));
    chk("short_lcnt", 64'(lcnt_c), 64'(0));
    chk("short_cnt", 64'(cnt_c), 64'(1));

    send_line(4, 8'h30);
    send_line(4, 8'h34);
    vs_close();
    chk("good_crc", 64'(crc_c), 64'(xcrc));
    chk("good_errs", 64'({len_c, lcnt_c}), 64'(0));
    chk("good_cnt", 64'(cnt_c), 64'(2));

    send_line(4, 8'h60);
    send_line(4, 8'h64);
    send_line(4, 8'h68);
    vs_close();
    chk("lines_crc", 64'(crc_c), 64'(xcrc));
    chk("lines_len", 64'(len_c), 64'(0));
    chk("lines_lcnt", 64'(lcnt_c), 64'(1));
    chk("lines_cnt", 64'(cnt_c), 64'(3));

    // vid_active high on the closing vsync edge
    send_line(4, 8'h40);
    for (int x = 0; x < 4; x++) begin
      p    = pix(8'h44 + x);
      mcrc = crc_model(mcrc, p, mbits);
      cyc(1'b1, 1'b0, p);
    end
    p    = pix(8'h80);
    cyc(1'b1, 1'b1, p);
    xcrc = ~mcrc;
    mcrc = crc_model(32'hFFFF_FFFF, p, mbits);
    chk("simul_done", 64'(dsnap_c), 64'(1));
    chk("simul_crc", 64'(crc_c), 64'(xcrc));
    chk("simul_errs", 64'({len_c, lcnt_c}), 64'(0));
    chk("wrap_to_0", 64'(cnt_c), 64'(0));
    for (int x = 1; x < 4; x++) begin
      p    = pix(8'h80 + x);
      mcrc = crc_model(mcrc, p, mbits);
      cyc(1'b1, 1'b0, p);
    end
    cyc(1'b0, 1'b0, 24'h0);
    send_line(4, 8'h90);
    vs_close();
    chk("simul_next_crc", 64'(crc_c), 64'(xcrc));
    chk("simul_next_errs", 64'({len_c, lcnt_c}), 64'(0));
    chk("wrap_to_1", 64'(cnt_c), 64'(1));

    // Reset in the middle of a line
    cyc(1'b1, 1'b0, 24'h05);
    cyc(1'b1, 1'b0, 24'h06);
    rst = 1'b1;
    tick();
    chk("midrst_crc", 64'(crc_c), 64'(0));
    chk("midrst_cnt", 64'(cnt_c), 64'(0));
    chk("midrst_busy", 64'(busy_c), 64'(0));
    chk("midrst_done", 64'(done_c), 64'(0));
    chk("midrst_crc_a", 64'(crc_a), 64'(0));
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
